sram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-port SRAM between the instruction-fetch port (A, read-only) and the load/store port (B, read/write with byte strobes) of the RISC-V core. It issues at most one SRAM access per cycle and expands B's byte strobes into the SRAM's per-bit write-enable mask. It routes the one-cycle-late SRAM read data back to the port that issued the read. It sits between the core's fetch/LSU and the SRAM macro. Throughput is one access per cycle.

---
 rtl/sram_arbiter.sv | 93 +++++++++
 tb/tb_sram_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a read-only fetch port (A)
// and a read/write load/store port (B); routes the registered read data back to its issuer.
module sram_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_a_req,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [WIDTH-1:0]      o_a_rdata,
  input  logic                  i_b_req,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [WIDTH-1:0]      i_b_wdata,
  input  logic [WIDTH/8-1:0]    i_b_wstrb,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [WIDTH-1:0]      o_b_rdata,
  output logic                  o_mem_cs,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_data,
  output logic [WIDTH-1:0]      o_mem_we,
  input  logic [WIDTH-1:0]      i_mem_data
);

  // state  | meaning
  // LAST_A | port A was granted most recently; B wins the next contention
  // LAST_B | port B was granted most recently (reset); A wins the next contention
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;

  localparam int NSTRB = WIDTH / 8;

  last_t            last_q, last_d;
  logic             rd_owner_a, rd_owner_b;
  logic             gnt_a, gnt_b;
  logic             b_is_read;
  logic [WIDTH-1:0] strb_mask;

  // Grants are masked combinationally while reset is held.
  assign gnt_a     = i_rstn & i_a_req & (~i_b_req | (last_q == LAST_B));
  assign gnt_b     = i_rstn & i_b_req & (~i_a_req | (last_q == LAST_A));
  assign b_is_read = (i_b_wstrb == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      last_q     <= LAST_B;
      rd_owner_a <= 1'b0;
      rd_owner_b <= 1'b0;
    end else begin
      last_q     <= last_d;
      rd_owner_a <= gnt_a;
      rd_owner_b <= gnt_b & b_is_read;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_a)      last_d = LAST_A;
    else if (gnt_b) last_d = LAST_B;
  end

  always_comb begin
    strb_mask = '0;
    for (int k = 0; k < NSTRB; k++) begin
      strb_mask[8*k +: 8] = {8{i_b_wstrb[k]}};
    end
  end

  always_comb begin
    o_a_gnt    = gnt_a;
    o_b_gnt    = gnt_b;
    o_mem_cs   = gnt_a | gnt_b;
    o_mem_addr = '0;
    o_mem_data = '0;
    o_mem_we   = '0;
    if (gnt_a) begin
      o_mem_addr = i_a_addr;
      o_mem_data = i_b_wdata;
    end else if (gnt_b) begin
      o_mem_addr = i_b_addr;
      o_mem_data = i_b_wdata;
      o_mem_we   = strb_mask;
    end
    // A read granted just before reset must not surface during the reset cycle.
    o_a_rvalid = rd_owner_a & i_rstn;
    o_b_rvalid = rd_owner_b & i_rstn;
    o_a_rdata  = i_mem_data;
    o_b_rdata  = i_mem_data;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed vector bench for sram_arbiter with a registered-read SRAM model attached.
module tb_sram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_a_req, i_b_req;
  logic [9:0]  i_a_addr, i_b_addr;
  logic [31:0] i_b_wdata;
  logic [3:0]  i_b_wstrb;
  logic        o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_mem_cs;
  logic [31:0] o_a_rdata, o_b_rdata, o_mem_data, o_mem_we;
  logic [9:0]  o_mem_addr;
  logic [31:0] i_mem_data;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  sram_arbiter #(.WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_a_req(i_a_req), .i_a_addr(i_a_addr), .o_a_gnt(o_a_gnt),
    .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
    .i_b_req(i_b_req), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata), .i_b_wstrb(i_b_wstrb),
    .o_b_gnt(o_b_gnt), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
    .o_mem_cs(o_mem_cs), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_we(o_mem_we), .i_mem_data(i_mem_data)
  );

  // SRAM model: per-bit write mask, read data registered one cycle after select.
  logic [31:0] mem [1024];
  logic        loaded = 1'b0;
  always @(posedge i_clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | i;
      mem[10'h010] <= 32'hDEADBEEF;
      mem[10'h020] <= 32'h12345678;
      mem[10'h3FF] <= 32'hAABBCCDD;
      loaded <= 1'b1;
    end else if (o_mem_cs) begin
      if (o_mem_we != '0)
        mem[o_mem_addr] <= (mem[o_mem_addr] & ~o_mem_we) | (o_mem_data & o_mem_we);
      else
        i_mem_data <= mem[o_mem_addr];
    end
  end

  typedef struct {
    logic        rstn;
    logic        a_req;
    logic [9:0]  a_addr;
    logic        b_req;
    logic [9:0]  b_addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  gnt;    // {a, b}
    logic        cs;
    logic [9:0]  maddr;
    logic [31:0] mdata;
    logic [31:0] we;
    logic [1:0]  rv;     // {a, b}
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rstn, logic a_req, logic [9:0] a_addr, logic b_req,
                              logic [9:0] b_addr, logic [31:0] wdata, logic [3:0] wstrb,
                              logic [1:0] gnt, logic cs, logic [9:0] maddr, logic [31:0] mdata,
                              logic [31:0] we, logic [1:0] rv, logic chk_rd, logic [31:0] rdata);
    vec_t v;
    v.rstn = rstn; v.a_req = a_req; v.a_addr = a_addr; v.b_req = b_req; v.b_addr = b_addr;
    v.wdata = wdata; v.wstrb = wstrb; v.gnt = gnt; v.cs = cs; v.maddr = maddr;
    v.mdata = mdata; v.we = we; v.rv = rv; v.chk_rd = chk_rd; v.rdata = rdata;
    return v;
  endfunction

  initial begin
    i_rstn = 1'b0; i_a_req = 1'b1; i_b_req = 1'b1;
    i_a_addr = 10'h010; i_b_addr = 10'h020; i_b_wdata = 32'h55555555; i_b_wstrb = 4'h0;

    // reset defaults, then first contention goes to A
    vecs.push_back(mk(0,1,10'h010,1,10'h020,32'h55555555,4'h0, 2'b00,0,10'h000,32'h0,32'h0, 2'b00,0,32'h0));
    vecs.push_back(mk(0,1,10'h010,1,10'h020,32'h55555555,4'h0, 2'b00,0,10'h000,32'h0,32'h0, 2'b00,0,32'h0));
    // continuous contention: A,B,A,B,A,B
    vecs.push_back(mk(1,1,10'h010,1,10'h020,32'h55555555,4'h0, 2'b10,1,10'h010,32'h55555555,32'h0, 2'b00,0,32'h0));
    vecs.push_back(mk(1,1,10'h011,1,10'h020,32'h0,4'h0, 2'b01,1,10'h020,32'h0,32'h0, 2'b10,1,32'hDEADBEEF));
    vecs.push_back(mk(1,1,10'h011,1,10'h021,32'h0,4'h0, 2'b10,1,10'h011,32'h0,32'h0, 2'b01,1,32'h12345678));
    vecs.push_back(mk(1,1,10'h012,1,10'h021,32'h0,4'h0, 2'b01,1,10'h021,32'h0,32'h0, 2'b10,1,32'hC0DE0011));
    vecs.push_back(mk(1,1,10'h012,1,10'h022,32'h0,4'h0, 2'b10,1,10'h012,32'h0,32'h0, 2'b01,1,32'hC0DE0021));
    vecs.push_back(mk(1,1,10'h013,1,10'h022,32'h0,4'h0, 2'b01,1,10'h022,32'h0,32'h0, 2'b10,1,32'hC0DE0012));
    vecs.push_back(mk(1,1,10'h013,0,10'h000,32'h0,4'h0, 2'b10,1,10'h013,32'h0,32'h0, 2'b01,1,32'hC0DE0022));
    // byte write, read-back, idle bus masking
    vecs.push_back(mk(1,0,10'h000,1,10'h3FF,32'h11223344,4'b0101, 2'b01,1,10'h3FF,32'h11223344,32'h00FF00FF, 2'b10,1,32'hC0DE0013));
    vecs.push_back(mk(1,0,10'h000,1,10'h3FF,32'h0,4'h0, 2'b01,1,10'h3FF,32'h0,32'h0, 2'b00,1,32'hC0DE0013));
    vecs.push_back(mk(1,0,10'h000,0,10'h000,32'hFFFFFFFF,4'hF, 2'b00,0,10'h000,32'h0,32'h0, 2'b01,1,32'hAA22CC44));
    // pipelined mix: A read, B write, B read same addr, A read
    vecs.push_back(mk(1,1,10'h010,0,10'h000,32'h0,4'h0, 2'b10,1,10'h010,32'h0,32'h0, 2'b00,0,32'h0));
    vecs.push_back(mk(1,0,10'h000,1,10'h030,32'hCAFEF00D,4'hF, 2'b01,1,10'h030,32'hCAFEF00D,32'hFFFFFFFF, 2'b10,1,32'hDEADBEEF));
    vecs.push_back(mk(1,0,10'h000,1,10'h030,32'h0,4'h0, 2'b01,1,10'h030,32'h0,32'h0, 2'b00,1,32'hDEADBEEF));
    vecs.push_back(mk(1,1,10'h011,0,10'h000,32'h0,4'h0, 2'b10,1,10'h011,32'h0,32'h0, 2'b01,1,32'hCAFEF00D));
    vecs.push_back(mk(1,0,10'h000,0,10'h000,32'h0,4'h0, 2'b00,0,10'h000,32'h0,32'h0, 2'b10,1,32'hC0DE0011));
    // solo B, then contention after B -> A
    vecs.push_back(mk(1,0,10'h000,1,10'h020,32'h0,4'h0, 2'b01,1,10'h020,32'h0,32'h0, 2'b00,1,32'hC0DE0011));
    vecs.push_back(mk(1,1,10'h010,1,10'h021,32'h0,4'h0, 2'b10,1,10'h010,32'h0,32'h0, 2'b01,1,32'h12345678));
    // reset right after an A read grant: no rvalid, last returns to B
    vecs.push_back(mk(0,1,10'h010,1,10'h021,32'h0,4'h0, 2'b00,0,10'h000,32'h0,32'h0, 2'b00,0,32'h0));
    vecs.push_back(mk(1,1,10'h011,1,10'h021,32'h0,4'h0, 2'b10,1,10'h011,32'h0,32'h0, 2'b00,0,32'h0));
    vecs.push_back(mk(1,0,10'h000,1,10'h021,32'h0,4'h0, 2'b01,1,10'h021,32'h0,32'h0, 2'b10,1,32'hC0DE0011));
    vecs.push_back(mk(1,0,10'h000,0,10'h000,32'h0,4'h0, 2'b00,0,10'h000,32'h0,32'h0, 2'b01,1,32'hC0DE0021));

    repeat (2) @(posedge i_clk);

    for (int n = 0; n < vecs.size(); n++) begin
      @(posedge i_clk);
      #1;
      i_rstn = vecs[n].rstn;
      i_a_req = vecs[n].a_req; i_a_addr = vecs[n].a_addr;
      i_b_req = vecs[n].b_req; i_b_addr = vecs[n].b_addr;
      i_b_wdata = vecs[n].wdata; i_b_wstrb = vecs[n].wstrb;
      @(negedge i_clk);

      checks++;
      if ({o_a_gnt, o_b_gnt} !== vecs[n].gnt) begin
        errors++;
        $display("FAIL vec%0d gnt: got a=%b b=%b, want %b", n, o_a_gnt, o_b_gnt, vecs[n].gnt);
      end
      checks++;
      if ({o_mem_cs, o_mem_addr, o_mem_data, o_mem_we} !==
          {vecs[n].cs, vecs[n].maddr, vecs[n].mdata, vecs[n].we}) begin
        errors++;
        $display("FAIL vec%0d mem_bus: got cs=%b addr=%h data=%h we=%h, want cs=%b addr=%h data=%h we=%h",
                 n, o_mem_cs, o_mem_addr, o_mem_data, o_mem_we,
                 vecs[n].cs, vecs[n].maddr, vecs[n].mdata, vecs[n].we);
      end
      checks++;
      if ({o_a_rvalid, o_b_rvalid} !== vecs[n].rv) begin
        errors++;
        $display("FAIL vec%0d rvalid: got a=%b b=%b, want %b", n, o_a_rvalid, o_b_rvalid, vecs[n].rv);
      end
      if (vecs[n].chk_rd) begin
        checks++;
        if ({o_a_rdata, o_b_rdata} !== {vecs[n].rdata, vecs[n].rdata}) begin
          errors++;
          $display("FAIL vec%0d rdata: got a=%h b=%h, want %h", n, o_a_rdata, o_b_rdata, vecs[n].rdata);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
